// File: rtl/dsp_rdata_ordered_channel.sv
// dsp_rdata_ordered_channel
// Read-data dispatcher for one master port. R beats from SLV_AMT slave
// ports are buffered in per-slave FIFOs. Bursts are returned strictly in AR
// issue order, which is tracked by an in-order queue of slave IDs. Beats
// reach the master through a registered two-entry output slice.
//
// Ports:
//   ACLK_i, ARESETn_i      clock, asynchronous active-low reset
//   sa_R*_i / sa_RREADY_o  packed per-slave R channels (ready = ~FIFO full)
//   dsp_AR_push_i/slv_id_i push of a target slave ID into the order queue
//   dsp_AR_ready_o         order queue not full
//   m_R*_o / m_RREADY_i    R channel towards the master
//   outst_cnt_o            order queue occupancy
module dsp_rdata_ordered_channel #(
  parameter int SLV_AMT         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_RD_RESP_W = 2,
  parameter int SLV_ID_W        = $clog2(SLV_AMT),
  parameter int DSP_RDATA_DEPTH = 16,
  parameter int OUTST_AMT       = 4
) (
  input  logic                                ACLK_i,
  input  logic                                ARESETn_i,
  input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]   sa_RID_i,
  input  logic [DATA_WIDTH*SLV_AMT-1:0]       sa_RDATA_i,
  input  logic [TRANS_RD_RESP_W*SLV_AMT-1:0]  sa_RRESP_i,
  input  logic [SLV_AMT-1:0]                  sa_RLAST_i,
  input  logic [SLV_AMT-1:0]                  sa_RVALID_i,
  output logic [SLV_AMT-1:0]                  sa_RREADY_o,
  input  logic                                dsp_AR_push_i,
  input  logic [SLV_ID_W-1:0]                 dsp_AR_slv_id_i,
  output logic                                dsp_AR_ready_o,
  output logic [TRANS_MST_ID_W-1:0]           m_RID_o,
  output logic [DATA_WIDTH-1:0]               m_RDATA_o,
  output logic [TRANS_RD_RESP_W-1:0]          m_RRESP_o,
  output logic                                m_RLAST_o,
  output logic                                m_RVALID_o,
  input  logic                                m_RREADY_i,
  output logic [$clog2(OUTST_AMT+1)-1:0]      outst_cnt_o
);

  localparam int BEAT_W = TRANS_MST_ID_W + DATA_WIDTH + TRANS_RD_RESP_W + 1;
  localparam int FAW    = $clog2(DSP_RDATA_DEPTH);
  localparam int QAW    = $clog2(OUTST_AMT);
  localparam int CNT_W  = $clog2(OUTST_AMT+1);

  typedef logic [BEAT_W-1:0] beat_t;  // {rid, data, resp, last}

  // Per-slave beat FIFOs
  beat_t          fifo_mem_q [SLV_AMT][DSP_RDATA_DEPTH];
  logic [FAW:0]   fifo_wptr_q [SLV_AMT];
  logic [FAW:0]   fifo_wptr_d [SLV_AMT];
  logic [FAW:0]   fifo_rptr_q [SLV_AMT];
  logic [FAW:0]   fifo_rptr_d [SLV_AMT];
  beat_t          fifo_wdata [SLV_AMT];
  logic [SLV_AMT-1:0] fifo_empty, fifo_full, fifo_wr, fifo_rd;

  // Order queue of target slave IDs
  logic [SLV_ID_W-1:0] oq_mem_q [OUTST_AMT];
  logic [QAW:0]        oq_wptr_q, oq_wptr_d, oq_rptr_q, oq_rptr_d;
  logic                oq_empty, oq_full, oq_push, oq_pop;
  logic [SLV_ID_W-1:0] head_id;

  // Output slice: slc0 is the head and drives the outputs directly
  beat_t      slc0_q, slc0_d, slc1_q, slc1_d;
  logic [1:0] slc_cnt_q, slc_cnt_d;
  logic       slc_pop;

  beat_t head_beat;
  logic  fwd;

  always_comb begin
    for (int unsigned s = 0; s < SLV_AMT; s++) begin
      fifo_empty[s] = (fifo_wptr_q[s] == fifo_rptr_q[s]);
      fifo_full[s]  = (fifo_wptr_q[s][FAW] != fifo_rptr_q[s][FAW]) &&
                      (fifo_wptr_q[s][FAW-1:0] == fifo_rptr_q[s][FAW-1:0]);
      fifo_wdata[s] = {sa_RID_i[s*TRANS_MST_ID_W +: TRANS_MST_ID_W],
                       sa_RDATA_i[s*DATA_WIDTH +: DATA_WIDTH],
                       sa_RRESP_i[s*TRANS_RD_RESP_W +: TRANS_RD_RESP_W],
                       sa_RLAST_i[s]};
    end
  end

  assign sa_RREADY_o = ~fifo_full;
  assign fifo_wr     = sa_RVALID_i & ~fifo_full;

  assign oq_empty       = (oq_wptr_q == oq_rptr_q);
  assign oq_full        = (oq_wptr_q[QAW] != oq_rptr_q[QAW]) &&
                          (oq_wptr_q[QAW-1:0] == oq_rptr_q[QAW-1:0]);
  assign oq_push        = dsp_AR_push_i & ~oq_full;
  assign dsp_AR_ready_o = ~oq_full;
  assign outst_cnt_o    = CNT_W'(oq_wptr_q - oq_rptr_q);

  assign head_id   = oq_mem_q[oq_rptr_q[QAW-1:0]];
  assign head_beat = fifo_mem_q[head_id][fifo_rptr_q[head_id][FAW-1:0]];
  // Only the head slave is ever drained; the slice gates on its current
  // occupancy, so a full slice stalls even while it is popping.
  assign fwd       = ~oq_empty & ~fifo_empty[head_id] & (slc_cnt_q != 2'd2);
  assign oq_pop    = fwd & head_beat[0];
  assign slc_pop   = (slc_cnt_q != 2'd0) & m_RREADY_i;

  always_comb begin
    fifo_rd = '0;
    if (fwd) fifo_rd[head_id] = 1'b1;
    for (int unsigned s = 0; s < SLV_AMT; s++) begin
      fifo_wptr_d[s] = fifo_wptr_q[s] + {{FAW{1'b0}}, fifo_wr[s]};
      fifo_rptr_d[s] = fifo_rptr_q[s] + {{FAW{1'b0}}, fifo_rd[s]};
    end
    oq_wptr_d = oq_wptr_q + {{QAW{1'b0}}, oq_push};
    oq_rptr_d = oq_rptr_q + {{QAW{1'b0}}, oq_pop};
  end

  // fwd implies fewer than two entries, so push+pop only happens with one
  // entry held: the new beat then lands straight in slc0.
  always_comb begin
    slc0_d    = slc0_q;
    slc1_d    = slc1_q;
    slc_cnt_d = slc_cnt_q;
    case ({slc_pop, fwd})
      2'b01: begin
        if (slc_cnt_q == 2'd0) slc0_d = head_beat;
        else                   slc1_d = head_beat;
        slc_cnt_d = slc_cnt_q + 2'd1;
      end
      2'b10: begin
        slc0_d    = slc1_q;
        slc_cnt_d = slc_cnt_q - 2'd1;
      end
      2'b11:   slc0_d = head_beat;
      default: ;
    endcase
  end

  assign {m_RID_o, m_RDATA_o, m_RRESP_o, m_RLAST_o} = slc0_q;
  assign m_RVALID_o = (slc_cnt_q != 2'd0);

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      for (int unsigned s = 0; s < SLV_AMT; s++) begin
        fifo_wptr_q[s] <= '0;
        fifo_rptr_q[s] <= '0;
      end
      oq_wptr_q <= '0;
      oq_rptr_q <= '0;
      slc0_q    <= '0;
      slc1_q    <= '0;
      slc_cnt_q <= '0;
    end else begin
      for (int unsigned s = 0; s < SLV_AMT; s++) begin
        fifo_wptr_q[s] <= fifo_wptr_d[s];
        fifo_rptr_q[s] <= fifo_rptr_d[s];
      end
      oq_wptr_q <= oq_wptr_d;
      oq_rptr_q <= oq_rptr_d;
      slc0_q    <= slc0_d;
      slc1_q    <= slc1_d;
      slc_cnt_q <= slc_cnt_d;
    end
  end

  // Storage arrays carry no reset; pointers define which entries are live.
  always_ff @(posedge ACLK_i) begin
    for (int unsigned s = 0; s < SLV_AMT; s++) begin
      if (fifo_wr[s]) fifo_mem_q[s][fifo_wptr_q[s][FAW-1:0]] <= fifo_wdata[s];
    end
    if (oq_push) oq_mem_q[oq_wptr_q[QAW-1:0]] <= dsp_AR_slv_id_i;
  end

endmodule

// File: tb/tb_dsp_rdata_ordered_channel.sv
module tb_dsp_rdata_ordered_channel;

  typedef struct packed {
    logic [4:0]  rid;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct packed {
    beat_t       b;
    logic [31:0] cyc;
  } rx_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sa_rid;
  logic [63:0] sa_rdata;
  logic [3:0]  sa_rresp;
  logic [1:0]  sa_rlast, sa_rvalid, sa_rready;
  logic        ar_push;
  logic [0:0]  ar_id;
  logic        ar_ready;
  logic [4:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, m_rvalid, m_rready;
  logic [2:0]  outst;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] cyc = 0;

  beat_t tx0[$];
  beat_t tx1[$];
  rx_t   rx[$];

  always #5 clk = ~clk;

  dsp_rdata_ordered_channel #(
    .SLV_AMT(2), .DATA_WIDTH(32), .TRANS_MST_ID_W(5), .TRANS_RD_RESP_W(2),
    .SLV_ID_W(1), .DSP_RDATA_DEPTH(16), .OUTST_AMT(4)
  ) dut (
    .ACLK_i(clk), .ARESETn_i(rst_n),
    .sa_RID_i(sa_rid), .sa_RDATA_i(sa_rdata), .sa_RRESP_i(sa_rresp),
    .sa_RLAST_i(sa_rlast), .sa_RVALID_i(sa_rvalid), .sa_RREADY_o(sa_rready),
    .dsp_AR_push_i(ar_push), .dsp_AR_slv_id_i(ar_id), .dsp_AR_ready_o(ar_ready),
    .m_RID_o(m_rid), .m_RDATA_o(m_rdata), .m_RRESP_o(m_rresp), .m_RLAST_o(m_rlast),
    .m_RVALID_o(m_rvalid), .m_RREADY_i(m_rready), .outst_cnt_o(outst)
  );

  // Inputs change #1 after posedge, so the negedge view is what the next
  // posedge will accept.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && m_rvalid && m_rready)
      rx.push_back('{b: '{rid: m_rid, data: m_rdata, resp: m_rresp, last: m_rlast}, cyc: cyc});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [4:0] rid, input logic [31:0] data,
                               input logic [1:0] resp, input logic last);
    mk = '{rid: rid, data: data, resp: resp, last: last};
  endfunction

  task automatic drive();
    sa_rvalid = '0; sa_rid = '0; sa_rdata = '0; sa_rresp = '0; sa_rlast = '0;
    if (tx0.size() > 0) begin
      sa_rvalid[0] = 1'b1; sa_rid[4:0] = tx0[0].rid; sa_rdata[31:0] = tx0[0].data;
      sa_rresp[1:0] = tx0[0].resp; sa_rlast[0] = tx0[0].last;
    end
    if (tx1.size() > 0) begin
      sa_rvalid[1] = 1'b1; sa_rid[9:5] = tx1[0].rid; sa_rdata[63:32] = tx1[0].data;
      sa_rresp[3:2] = tx1[0].resp; sa_rlast[1] = tx1[0].last;
    end
  endtask

  task automatic tick();
    logic [1:0] hs;
    hs = sa_rvalid & sa_rready;
    @(posedge clk);
    #1;
    if (hs[0]) void'(tx0.pop_front());
    if (hs[1]) void'(tx1.pop_front());
    drive();
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    logic busy;
    busy = 1'b1;
    for (int unsigned i = 0; i < budget; i++) begin
      busy = (tx0.size() != 0) || (tx1.size() != 0) || m_rvalid;
      if (!busy) break;
      tick();
    end
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic push(input logic id);
    ar_push = 1'b1; ar_id = id;
    tick();
    ar_push = 1'b0;
  endtask

  task automatic check_rx(input string tag, input int unsigned idx,
                          input logic [31:0] data, input logic last);
    if (idx < rx.size())
      check(tag, {31'd0, rx[idx].b.last, rx[idx].b.data}, {31'd0, last, data});
  endtask

  initial begin
    int unsigned base;
    rst_n = 1'b0; ar_push = 1'b0; ar_id = '0; m_rready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", {63'd0, m_rvalid}, 64'd0);
    check("rst_rdata", {32'd0, m_rdata}, 64'd0);
    check("rst_outst", {61'd0, outst}, 64'd0);
    check("rst_ar_ready", {63'd0, ar_ready}, 64'd1);
    check("rst_sa_rready", {62'd0, sa_rready}, 64'd3);
    rst_n = 1'b1;
    tick();

    // Single burst from slave 1
    base = rx.size();
    push(1'b1);
    check("t1_outst_push", {61'd0, outst}, 64'd1);
    for (int unsigned i = 0; i < 4; i++) tx1.push_back(mk(5'd3, 32'h100 + i, 2'b10, i == 3));
    drive();
    tick();
    check("t1_rvalid_early", {63'd0, m_rvalid}, 64'd0);
    tick();
    check("t1_rvalid_lat2", {63'd0, m_rvalid}, 64'd1);
    check("t1_rid", {59'd0, m_rid}, 64'd3);
    check("t1_rresp", {62'd0, m_rresp}, 64'd2);
    check("t1_outst_mid", {61'd0, outst}, 64'd1);
    repeat (3) tick();
    check("t1_rlast", {63'd0, m_rlast}, 64'd1);
    check("t1_outst_done", {61'd0, outst}, 64'd0);
    wait_idle("t1", 20);
    check("t1_count", 64'(rx.size() - base), 64'd4);
    for (int unsigned i = 0; i < 4; i++) check_rx("t1_beat", base + i, 32'h100 + i, i == 3);
    if (rx.size() >= base + 4)
      check("t1_back2back", 64'(rx[base+3].cyc - rx[base].cyc), 64'd3);

    // Reordering: slave 1 data arrives first but slave 0 was issued first
    base = rx.size();
    push(1'b0);
    push(1'b1);
    check("t2_outst", {61'd0, outst}, 64'd2);
    tx1.push_back(mk(5'd7, 32'h200, 2'b00, 1'b0));
    tx1.push_back(mk(5'd7, 32'h201, 2'b00, 1'b1));
    drive();
    repeat (5) tick();
    check("t2_hold_nonhead", {63'd0, m_rvalid}, 64'd0);
    for (int unsigned i = 0; i < 3; i++) tx0.push_back(mk(5'd2, 32'h300 + i, 2'b00, i == 2));
    drive();
    wait_idle("t2", 30);
    check("t2_count", 64'(rx.size() - base), 64'd5);
    check_rx("t2_b0", base + 0, 32'h300, 1'b0);
    check_rx("t2_b1", base + 1, 32'h301, 1'b0);
    check_rx("t2_b2", base + 2, 32'h302, 1'b1);
    check_rx("t2_b3", base + 3, 32'h200, 1'b0);
    check_rx("t2_b4", base + 4, 32'h201, 1'b1);
    if (rx.size() >= base + 5)
      check("t2_no_gap", 64'(rx[base+3].cyc - rx[base+2].cyc), 64'd1);

    // Order queue full
    base = rx.size();
    for (int unsigned i = 0; i < 4; i++) push(i[0]);
    check("t3_ar_ready_full", {63'd0, ar_ready}, 64'd0);
    check("t3_outst_full", {61'd0, outst}, 64'd4);
    push(1'b1);
    check("t3_push_ignored", {61'd0, outst}, 64'd4);
    tx0.push_back(mk(5'd1, 32'h400, 2'b00, 1'b1));
    drive();
    tick();
    check("t3_ready_before_pop", {63'd0, ar_ready}, 64'd0);
    tick();
    check("t3_ready_after_pop", {63'd0, ar_ready}, 64'd1);
    check("t3_outst_after_pop", {61'd0, outst}, 64'd3);
    tx1.push_back(mk(5'd1, 32'h401, 2'b00, 1'b1));
    tx0.push_back(mk(5'd1, 32'h402, 2'b00, 1'b1));
    tx1.push_back(mk(5'd1, 32'h403, 2'b00, 1'b1));
    drive();
    wait_idle("t3", 30);
    check("t3_outst_end", {61'd0, outst}, 64'd0);
    check("t3_count", 64'(rx.size() - base), 64'd4);
    for (int unsigned i = 0; i < 4; i++) check_rx("t3_beat", base + i, 32'h400 + i, 1'b1);

    // Backpressure: slice holds 2, FIFO holds 16
    base = rx.size();
    m_rready = 1'b0;
    push(1'b0);
    for (int unsigned i = 0; i < 20; i++) tx0.push_back(mk(5'd4, 32'h500 + i, 2'b01, i == 19));
    drive();
    repeat (25) tick();
    check("t4_sa_rready_full", {63'd0, sa_rready[0]}, 64'd0);
    check("t4_sa_rready_other", {63'd0, sa_rready[1]}, 64'd1);
    check("t4_accepted", 64'(tx0.size()), 64'd2);
    check("t4_head_data", {32'd0, m_rdata}, 64'h500);
    m_rready = 1'b1;
    wait_idle("t4", 60);
    check("t4_count", 64'(rx.size() - base), 64'd20);
    for (int unsigned i = 0; i < 20; i++) check_rx("t4_beat", base + i, 32'h500 + i, i == 19);
    check("t4_outst_end", {61'd0, outst}, 64'd0);

    // Reset mid-burst after two of four beats delivered
    base = rx.size();
    push(1'b1);
    for (int unsigned i = 0; i < 4; i++) tx1.push_back(mk(5'd5, 32'h600 + i, 2'b00, i == 3));
    drive();
    for (int unsigned i = 0; i < 20; i++) begin
      if (rx.size() >= base + 2) break;
      tick();
    end
    check("t5_two_delivered", 64'(rx.size() - base), 64'd2);
    check("t5_rvalid_before", {63'd0, m_rvalid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rvalid", {63'd0, m_rvalid}, 64'd0);
    check("t5_rst_outst", {61'd0, outst}, 64'd0);
    check("t5_rst_ar_ready", {63'd0, ar_ready}, 64'd1);
    check("t5_rst_sa_rready", {62'd0, sa_rready}, 64'd3);
    tx0.delete();
    tx1.delete();
    drive();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("t5_dropped", 64'(rx.size() - base), 64'd2);
    check("t5_idle_rvalid", {63'd0, m_rvalid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
